// File: rtl/dut_vector_sequencer.sv
// rtl/dut_vector_sequencer.sv - applies buffered test vectors to DUT pins and writes captured pin samples back
module dut_vector_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  go,
    input  logic [DATA_WIDTH-1:0] dut_ctrl,
    input  logic [ADDR_WIDTH:0]   burst_size,
    output logic                  finished,
    output logic                  busy,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [DATA_WIDTH-1:0] dut_out,
    output logic [DATA_WIDTH-1:0] dut_oe,
    input  logic [DATA_WIDTH-1:0] dut_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0]            SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_next;
    logic [DATA_WIDTH-1:0]   r_ctrl;
    logic [ADDR_WIDTH-1:0]   r_last;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [3:0]              r_settle;
    logic [DATA_WIDTH-1:0]   r_cap;
    logic [DATA_WIDTH-1:0]   r_dut_out;
    logic [DATA_WIDTH-1:0]   r_dut_oe;
    logic [ADDR_WIDTH-1:0]   w_last;
    logic                    w_busy;
    logic                    w_is_last;

    // Any burst of 2^ADDR_WIDTH or more clamps to the full buffer, so the last index is all ones.
    assign w_last    = burst_size[ADDR_WIDTH] ? {ADDR_WIDTH{1'b1}}
                                              : burst_size[ADDR_WIDTH-1:0] - IDX_ONE;
    assign w_is_last = (r_idx == r_last);
    assign w_busy    = (r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_SETTLE) ||
                       (r_state == S_CAPTURE) || (r_state == S_WRITE);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_next = (burst_size == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:   w_next = go ? S_LOAD : S_IDLE;
            S_LOAD:    w_next = go ? S_SETTLE : S_IDLE;
            S_SETTLE: begin
                if (!go) begin
                    w_next = S_IDLE;
                end else if (r_settle <= 4'd1) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: w_next = go ? S_WRITE : S_IDLE;
            S_WRITE: begin
                if (!go) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = w_is_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                if (!go) begin
                    w_next = S_IDLE;
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_ctrl    <= '0;
            r_last    <= '0;
            r_idx     <= '0;
            r_settle  <= '0;
            r_cap     <= '0;
            r_dut_out <= '0;
            r_dut_oe  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_ctrl <= dut_ctrl;
                        r_last <= w_last;
                        r_idx  <= '0;
                    end
                end
                S_LOAD: begin
                    if (go) begin
                        r_dut_out <= mem_rd_data;
                        r_dut_oe  <= r_ctrl;
                        r_settle  <= SETTLE_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (r_settle != 4'd0) begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    r_cap <= dut_in & ~r_ctrl;
                end
                S_WRITE: begin
                    if (go && !w_is_last) begin
                        r_idx <= r_idx + IDX_ONE;
                    end
                    if (go && w_is_last) begin
                        r_dut_oe <= '0;
                    end
                end
                default: begin
                end
            endcase
            // Aborting releases the bus; the pin values themselves are left as they were.
            if (w_busy && !go) begin
                r_dut_oe <= '0;
            end
        end
    end

    assign busy        = w_busy;
    assign finished    = (r_state == S_DONE);
    assign mem_rd_en   = (r_state == S_FETCH);
    assign mem_rd_addr = mem_rd_en ? r_idx : '0;
    assign mem_wr_en   = (r_state == S_WRITE) && go;
    assign mem_wr_addr = mem_wr_en ? r_idx : '0;
    assign mem_wr_data = mem_wr_en ? r_cap : '0;
    assign dut_out     = r_dut_out;
    assign dut_oe      = r_dut_oe;

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// tb/tb_dut_vector_sequencer.sv - directed scoreboard bench for dut_vector_sequencer
module tb_dut_vector_sequencer;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        go;
    logic [31:0] dut_ctrl;
    logic [8:0]  burst_size;
    logic        finished;
    logic        busy;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] dut_out;
    logic [31:0] dut_oe;
    logic [31:0] dut_in;

    logic        go3;
    logic [31:0] dut_ctrl3;
    logic [8:0]  burst3;
    logic        finished3;
    logic        busy3;
    logic        mem_rd_en3;
    logic [7:0]  mem_rd_addr3;
    logic [31:0] mem_rd_data3;
    logic        mem_wr_en3;
    logic [7:0]  mem_wr_addr3;
    logic [31:0] mem_wr_data3;
    logic [31:0] dut_out3;
    logic [31:0] dut_oe3;
    logic [31:0] dut_in3;

    logic [31:0] rd_mul;
    logic [31:0] rd_add;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] pins;
        logic [31:0] oe;
        int          cyc;
    } wr_t;

    wr_t         sb[$];
    int          rd3_cyc[$];
    int          wr3_cyc[$];
    logic [31:0] wr3_data[$];
    int          fin3_cyc;
    int          n_vec;
    int          n_miss;
    int          cyc;
    int          n_rd;
    int          n_wr;
    int          last_wr_addr;

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (mem_rd_en) mem_rd_data <= rd_mul * 32'(mem_rd_addr) + rd_add;
        if (mem_rd_en3) mem_rd_data3 <= 32'(mem_rd_addr3) * 32'd5 + 32'd1;
    end

    dut_vector_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .SETTLE_CYCLES(1)) u_dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .go(go), .dut_ctrl(dut_ctrl), .burst_size(burst_size),
        .finished(finished), .busy(busy), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .dut_out(dut_out), .dut_oe(dut_oe), .dut_in(dut_in)
    );

    dut_vector_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .SETTLE_CYCLES(3)) u_dut3 (
        .ACLK(ACLK), .ARESETN(ARESETN), .go(go3), .dut_ctrl(dut_ctrl3), .burst_size(burst3),
        .finished(finished3), .busy(busy3), .mem_rd_en(mem_rd_en3), .mem_rd_addr(mem_rd_addr3),
        .mem_rd_data(mem_rd_data3), .mem_wr_en(mem_wr_en3), .mem_wr_addr(mem_wr_addr3),
        .mem_wr_data(mem_wr_data3), .dut_out(dut_out3), .dut_oe(dut_oe3), .dut_in(dut_in3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        wr_t e;
        @(negedge ACLK);
        cyc++;
        if (mem_rd_en) n_rd++;
        if (mem_wr_en) begin
            n_wr++;
            last_wr_addr = 32'(mem_wr_addr);
            check("rd_during_wr", 32'(mem_rd_en), 32'd0);
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $error("FAIL unexpected_write: observed addr %h data %h expected no write", mem_wr_addr, mem_wr_data);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(mem_wr_addr), 32'(e.addr));
                check("wr_data", mem_wr_data, e.data);
                check("wr_cycle", cyc, e.cyc);
                check("pins_at_wr", dut_out, e.pins);
                check("oe_at_wr", dut_oe, e.oe);
            end
        end
        if (mem_rd_en3) rd3_cyc.push_back(cyc);
        if (mem_wr_en3) begin
            wr3_cyc.push_back(cyc);
            wr3_data.push_back(mem_wr_data3);
        end
        if (finished3 && fin3_cyc < 0) fin3_cyc = cyc;
    endtask

    task automatic start_run(input int nburst, input int npush, input logic [31:0] ctrl,
                             input logic [31:0] din, input logic [31:0] mul);
        dut_ctrl   = ctrl;
        burst_size = 9'(nburst);
        dut_in     = din;
        rd_mul     = mul;
        go         = 1'b1;
        for (int i = 0; i < npush; i++) begin
            sb.push_back('{addr: 8'(i), data: din & ~ctrl, pins: mul * 32'(i) + rd_add,
                           oe: ctrl, cyc: cyc + 5 * (i + 1)});
        end
    endtask

    task automatic wait_finished(input int budget, output int fcyc);
        fcyc = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (finished) begin
                fcyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int f;
        int rd0;
        int wr0;
        n_vec = 0; n_miss = 0; cyc = 0; n_rd = 0; n_wr = 0; last_wr_addr = -1; fin3_cyc = -1;
        ARESETN = 1'b0; go = 1'b0; dut_ctrl = '0; burst_size = '0; dut_in = '0;
        rd_mul = '0; rd_add = '0;
        go3 = 1'b0; dut_ctrl3 = '0; burst3 = '0; dut_in3 = '0;
        step();
        step();
        check("rst_finished", 32'(finished), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_en", 32'(mem_rd_en), 0);
        check("rst_wr_en", 32'(mem_wr_en), 0);
        check("rst_oe", dut_oe, 0);
        check("rst_out", dut_out, 0);
        ARESETN = 1'b1;
        step();

        // full buffer, all pins tester-driven
        wr0 = n_wr;
        start_run(256, 256, 32'hFFFF_FFFF, 32'h5A5A_1234, 32'd2);
        k = cyc;
        wait_finished(1400, f);
        check("t1_finish_cycle", f, k + 1281);
        check("t1_writes", n_wr - wr0, 256);
        check("t1_pending", sb.size(), 0);
        check("t1_done_oe", dut_oe, 0);
        check("t1_hold_out", dut_out, 32'h1FE);
        go = 1'b0;
        step();
        check("t1_finished_clr", 32'(finished), 0);
        step();

        // mixed direction mask; mid-run changes to ctrl/burst must be ignored
        wr0 = n_wr;
        start_run(4, 4, 32'h00C0_00BC, 32'hFFFF_FFFF, 32'd7);
        k = cyc;
        step();
        step();
        dut_ctrl = 32'h0;
        burst_size = 9'd1;
        wait_finished(100, f);
        check("t2_finish_cycle", f, k + 21);
        check("t2_writes", n_wr - wr0, 4);
        check("t2_done_oe", dut_oe, 0);
        go = 1'b0;
        step();

        // empty burst
        rd0 = n_rd; wr0 = n_wr;
        start_run(0, 0, 32'h1234_5678, 32'h0, 32'd1);
        step();
        check("t3_finished", 32'(finished), 1);
        check("t3_busy", 32'(busy), 0);
        repeat (5) step();
        check("t3_finished_hold", 32'(finished), 1);
        check("t3_busy_hold", 32'(busy), 0);
        check("t3_reads", n_rd - rd0, 0);
        check("t3_writes", n_wr - wr0, 0);
        go = 1'b0;
        step();
        check("t3_finished_clr", 32'(finished), 0);

        // oversize burst clamps to the buffer size
        rd0 = n_rd; wr0 = n_wr;
        start_run(300, 256, 32'h0000_FFFF, 32'hABCD_1234, 32'd1);
        k = cyc;
        wait_finished(1400, f);
        check("t4_finish_cycle", f, k + 1281);
        check("t4_last_addr", last_wr_addr, 255);
        check("t4_writes", n_wr - wr0, 256);
        check("t4_reads", n_rd - rd0, 256);
        go = 1'b0;
        step();

        // abort during SETTLE of vector 3, then restart
        wr0 = n_wr;
        start_run(8, 3, 32'hFFFF_0000, 32'h1357_2468, 32'd3);
        k = cyc;
        repeat (18) step();
        check("t5_busy_settle", 32'(busy), 1);
        go = 1'b0;
        step();
        check("t5_busy", 32'(busy), 0);
        check("t5_finished", 32'(finished), 0);
        check("t5_oe", dut_oe, 0);
        repeat (3) step();
        check("t5_writes", n_wr - wr0, 3);
        check("t5_pending", sb.size(), 0);
        start_run(2, 2, 32'h0F00_0000, 32'h2468_ACE0, 32'd9);
        step();
        check("t5_restart_rd", 32'(mem_rd_en), 1);
        check("t5_restart_addr", 32'(mem_rd_addr), 0);
        wait_finished(50, f);
        check("t5_restart_done", 32'(finished), 1);
        go = 1'b0;
        step();

        // reset pulse during CAPTURE
        wr0 = n_wr;
        rd_add = 32'hDEAD_0000;
        start_run(4, 0, 32'hF0F0_F0F0, 32'h5555_AAAA, 32'd1);
        repeat (4) step();
        check("t6_busy_capture", 32'(busy), 1);
        ARESETN = 1'b0;
        step();
        check("t6_finished", 32'(finished), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_rd_en", 32'(mem_rd_en), 0);
        check("t6_rd_addr", 32'(mem_rd_addr), 0);
        check("t6_wr_en", 32'(mem_wr_en), 0);
        check("t6_wr_addr", 32'(mem_wr_addr), 0);
        check("t6_wr_data", mem_wr_data, 0);
        check("t6_out", dut_out, 0);
        check("t6_oe", dut_oe, 0);
        ARESETN = 1'b1;
        go = 1'b0;
        repeat (4) step();
        check("t6_writes", n_wr - wr0, 0);

        // SETTLE_CYCLES=3 instance: 7-cycle vector period
        dut_ctrl3 = 32'h0000_00FF;
        burst3 = 9'd2;
        dut_in3 = 32'h0F0F_0F0F;
        go3 = 1'b1;
        k = cyc;
        repeat (20) step();
        check("t7_reads", rd3_cyc.size(), 2);
        check("t7_first_rd", (rd3_cyc.size() >= 1) ? rd3_cyc[0] : -1, k + 1);
        check("t7_period", (rd3_cyc.size() >= 2) ? rd3_cyc[1] - rd3_cyc[0] : -1, 7);
        check("t7_writes", wr3_cyc.size(), 2);
        check("t7_wr0_cycle", (wr3_cyc.size() >= 1) ? wr3_cyc[0] : -1, k + 7);
        check("t7_wr1_cycle", (wr3_cyc.size() >= 2) ? wr3_cyc[1] : -1, k + 14);
        check("t7_wr_data", (wr3_data.size() >= 1) ? wr3_data[0] : 32'hFFFF_FFFF, 32'h0F0F_0F00);
        check("t7_finish_cycle", fin3_cyc, k + 15);
        check("t7_hold_out", dut_out3, 32'd6);
        check("t7_done_oe", dut_oe3, 0);
        go3 = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dut_vector_sequencer.md
Name: dut_vector_sequencer

Overview:
- Core engine between the test-vector buffer (written by the AXI4 full slave) and the DUT pins.
- On `go`, it reads each stored vector in turn and drives the tester-owned pins with it.
- It then waits a settle time, samples the DUT-owned pins and writes the sample back over the vector at the same buffer address.
- On completion it raises `finished` for the AXI4-Lite status/finished registers.

Parameters:
- DATA_WIDTH, 32, DUT bus and buffer word width
- ADDR_WIDTH, 8, buffer word-address width (256 vectors)
- SETTLE_CYCLES, 1, cycles between applying a vector and sampling; legal range 1..15

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  synchronous active-low reset
- go  in  1  run request from the status register, bit 0; level-sensitive
- dut_ctrl  in  DATA_WIDTH  pin direction mask; 1 = tester drives the pin, 0 = DUT drives the pin
- burst_size  in  ADDR_WIDTH+1  number of vectors to apply, 0..2^ADDR_WIDTH
- finished  out  1  run complete; feeds the finished register
- busy  out  1  high in any state other than IDLE and DONE
- mem_rd_en  out  1  buffer read strobe
- mem_rd_addr  out  ADDR_WIDTH  buffer read word address
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
- mem_wr_en  out  1  buffer write strobe
- mem_wr_addr  out  ADDR_WIDTH  buffer write word address
- mem_wr_data  out  DATA_WIDTH  captured result word
- dut_out  out  DATA_WIDTH  values driven onto the pins
- dut_oe  out  DATA_WIDTH  per-bit output enable to the pad tristate
- dut_in  in  DATA_WIDTH  pin values as seen at the pads

Behaviour:
- Reset (ARESETN=0 at a rising ACLK edge):
  - state=IDLE.
  - All outputs 0, including dut_oe=0, so the bus is released.
  - Index counter 0, settle counter 0.
  - Reset asserted mid-run aborts the run immediately; no further memory accesses occur.
- IDLE:
  - When go=1, latch dut_ctrl into ctrl_q and latch n = min(burst_size, 2^ADDR_WIDTH). Set idx=0.
  - If n=0, go to DONE with no memory access. Otherwise go to FETCH.
- FETCH (1 cycle): mem_rd_en=1, mem_rd_addr=idx. Go to LOAD.
- LOAD (1 cycle):
  - Register dut_out <= mem_rd_data and dut_oe <= ctrl_q.
  - Pins change at the end of this cycle. Load the settle counter with SETTLE_CYCLES.
  - Go to SETTLE.
- SETTLE: decrement the counter each cycle; stay SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE (1 cycle): cap_q <= dut_in & ~ctrl_q. Tester-driven bits read back as 0. Go to WRITE.
- WRITE (1 cycle):
  - mem_wr_en=1, mem_wr_addr=idx, mem_wr_data=cap_q.
  - If idx=n-1, go to DONE. Otherwise idx <= idx+1 and go to FETCH.
- Per-vector period is 4+SETTLE_CYCLES cycles (5 at the default).
- dut_out and dut_oe hold their value between vectors; they are only updated in LOAD.
- DONE:
  - finished=1, dut_oe=0.
  - Hold while go=1. When go=0, finished <= 0 and return to IDLE.
  - A new run therefore requires go to fall and rise again.
- Abort: go=0 in any of FETCH..WRITE returns to IDLE on the next edge.
  - dut_oe=0, finished stays 0.
  - A write pending in that cycle is suppressed: mem_wr_en is qualified by go.
- dut_ctrl and burst_size changes during a run have no effect; only the values latched in IDLE are used.
- idx is ADDR_WIDTH bits wide.
  - n=2^ADDR_WIDTH is compared against idx=2^ADDR_WIDTH-1 and terminates without wrap.
  - No address beyond 2^ADDR_WIDTH-1 is ever issued.
- Strobe and state rules:
  - mem_rd_en and mem_wr_en are never asserted in the same cycle.
  - Each is a single-cycle pulse per vector.
  - busy=1 in FETCH, LOAD, SETTLE, CAPTURE and WRITE.

Test Plan:
1. Buffer[i]=i*2 for i=0..255, dut_ctrl=0xFFFFFFFF, burst_size=256, go=1 held:
   - dut_out steps 0,2,4,... every 5 cycles.
   - 256 writes of 0x0.
   - finished=1 exactly 1280 cycles after entering FETCH.
   - Dropping go clears finished next cycle.
2. dut_ctrl=0x00C000BC, burst_size=4, dut_in forced to 0xFFFFFFFF:
   - dut_oe=0x00C000BC during the run.
   - Each written word = 0xFF3FFF43.
   - Addresses 0..3 written once each; dut_oe=0 in DONE.
3. burst_size=0, go=1: finished=1 on the second cycle, no mem_rd_en/mem_wr_en ever, busy stays 0.
4. burst_size=300: exactly 256 vectors processed; last write address 0xFF; no address wrap.
5. go dropped during the SETTLE of vector 3: no write to address 3, state IDLE, dut_oe=0, finished=0. A re-raised go restarts from address 0.
6. ARESETN pulsed low during CAPTURE: the next cycle shows all outputs 0 and state IDLE.
7. SETTLE_CYCLES=3, burst_size=2: period is 7 cycles per vector.
